// File: rtl/cp0_ctrl.sv
// Coprocessor-0 control: SR/Cause/EPC/PRId registers, interrupt/exception request
// generation and mtc0/mfc0/eret handling for a 5-stage MIPS-style pipeline.
module cp0_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL   = 32'h2023_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic [4:0]  ExcCodeM,
  input  logic [5:0]  HWInt,
  input  logic        WE,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0In,
  input  logic        EXLClr,
  output logic [31:0] CP0Out,
  output logic [31:0] EPCOut,
  output logic        Req,
  output logic [31:0] HandlerPC
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  // Implemented register fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  // Request terms are purely combinational; EXL masks nesting, reset forces Req low
  always_comb begin
    w_int_req = (|(HWInt & r_im)) & r_ie & ~r_exl;
    w_exc_req = (ExcCodeM != 5'd0) & ~r_exl;
    w_req     = reset & (w_int_req | w_exc_req);
    w_wr_sr   = WE & ~w_req & (CP0Addr == AddrSr);
    w_wr_epc  = WE & ~w_req & (CP0Addr == AddrEpc);
  end

  assign Req       = w_req;
  assign HandlerPC = HANDLER_PC;

  // Register state: exception entry beats eret, which beats mtc0; IP samples HWInt every edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im      <= 6'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= HWInt;
      if (w_req) begin
        r_exl     <= 1'b1;
        r_bd      <= BDM;
        r_exccode <= w_int_req ? 5'd0 : ExcCodeM;
        r_epc     <= BDM ? (PCM - 32'd4) : PCM;
      end else begin
        if (w_wr_sr) begin
          r_im <= CP0In[15:10];
          r_ie <= CP0In[0];
        end
        // eret clear wins over an mtc0 SR write of EXL on the same edge
        if (EXLClr) begin
          r_exl <= 1'b0;
        end else if (w_wr_sr) begin
          r_exl <= CP0In[1];
        end
        if (w_wr_epc) begin
          r_epc <= CP0In;
        end
      end
    end
  end

  // Assemble architectural views and the mfc0 read mux (pre-write values)
  always_comb begin
    w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
    w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'd0};
    CP0Out  = 32'd0;
    unique case (CP0Addr)
      AddrSr:    CP0Out = w_sr;
      AddrCause: CP0Out = w_cause;
      AddrEpc:   CP0Out = r_epc;
      AddrPrid:  CP0Out = PRID_VAL;
      default:   CP0Out = 32'd0;
    endcase
  end

  // eret target, bypassing an mtc0 EPC in the same cycle
  always_comb begin
    EPCOut = w_wr_epc ? CP0In : r_epc;
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios plus randomized traffic
// checked against a word-level behavioural model of the CP0 registers.
module tb_cp0_ctrl;

  localparam logic [31:0] HPC  = 32'h0000_4180;
  localparam logic [31:0] PRID = 32'h2023_0007;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PCM = '0;
  logic        BDM = 1'b0;
  logic [4:0]  ExcCodeM = '0;
  logic [5:0]  HWInt = '0;
  logic        WE = 1'b0;
  logic [4:0]  CP0Addr = '0;
  logic [31:0] CP0In = '0;
  logic        EXLClr = 1'b0;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;
  logic [31:0] HandlerPC;

  always #10 clk = ~clk;

  cp0_ctrl #(
    .HANDLER_PC(HPC),
    .PRID_VAL  (PRID)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .PCM      (PCM),
    .BDM      (BDM),
    .ExcCodeM (ExcCodeM),
    .HWInt    (HWInt),
    .WE       (WE),
    .CP0Addr  (CP0Addr),
    .CP0In    (CP0In),
    .EXLClr   (EXLClr),
    .CP0Out   (CP0Out),
    .EPCOut   (EPCOut),
    .Req      (Req),
    .HandlerPC(HandlerPC)
  );

  // Model: architectural register words
  logic [31:0] m_sr, m_cause, m_epc;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int();
    return (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return reset && (m_int() || (ExcCodeM != 5'd0 && !m_sr[1]));
  endfunction

  task automatic m_clear();
    m_sr = '0; m_cause = '0; m_epc = '0;
  endtask

  task automatic model_edge();
    logic req, intr;
    if (!reset) begin
      m_clear();
      return;
    end
    req  = m_req();
    intr = m_int();
    if (req) begin
      m_sr[1]       = 1'b1;
      m_cause[31]   = BDM;
      m_cause[6:2]  = intr ? 5'd0 : ExcCodeM;
      m_epc         = BDM ? PCM - 32'd4 : PCM;
    end else begin
      if (WE && CP0Addr == 5'd12) m_sr = CP0In & 32'h0000_FC03;
      if (WE && CP0Addr == 5'd14) m_epc = CP0In;
      if (EXLClr) m_sr[1] = 1'b0;
    end
    m_cause[15:10] = HWInt;
  endtask

  task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] din,
                       input logic [4:0] exc, input logic bd, input logic [31:0] pc,
                       input logic [5:0] hw, input logic clr);
    WE = we; CP0Addr = addr; CP0In = din; ExcCodeM = exc;
    BDM = bd; PCM = pc; HWInt = hw; EXLClr = clr;
  endtask

  // Called at a negedge with inputs set: check comb outputs, advance model and DUT one edge
  task automatic cycle(input string where);
    logic [31:0] exp_epc;
    #1;
    exp_epc = (WE && CP0Addr == 5'd14 && !m_req()) ? CP0In : m_epc;
    check_eq({where, ":Req"}, {31'd0, Req}, {31'd0, m_req()});
    check_eq({where, ":CP0Out"}, CP0Out, m_read(CP0Addr));
    check_eq({where, ":EPCOut"}, EPCOut, exp_epc);
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Read an address before the next edge and compare with a fixed expected value
  task automatic read_exp(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    drive(1'b0, addr, 32'd0, 5'd0, 1'b0, 32'd0, HWInt, 1'b0);
    #1;
    check_eq(tag, CP0Out, exp);
  endtask

  initial begin
    m_clear();
    // Reset held with a pending exception: Req stays low, state reads 0
    drive(1'b0, 5'd12, 32'd0, 5'd4, 1'b0, 32'h100, 6'h3F, 1'b0);
    @(negedge clk);
    #1;
    check_eq("rst:Req", {31'd0, Req}, 32'd0);
    check_eq("rst:HandlerPC", HandlerPC, HPC);
    for (int a = 12; a <= 15; a++) begin
      CP0Addr = 5'(a);
      #1;
      check_eq("rst:read", CP0Out, (a == 15) ? PRID : 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd13, 32'd0, 5'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    cycle("post_rst");

    // Interrupt entry
    drive(1'b1, 5'd12, 32'h0000_FC01, 5'd0, 1'b0, 32'h0000_1000, 6'd0, 1'b0);
    cycle("s1_mtc0");
    drive(1'b0, 5'd12, 32'd0, 5'd0, 1'b0, 32'h0000_1000, 6'b000100, 1'b0);
    #1;
    check_eq("s1:req_now", {31'd0, Req}, 32'd1);
    cycle("s1_int");
    read_exp("s1:sr", 5'd12, 32'h0000_FC03);
    check_eq("s1:req_after", {31'd0, Req}, 32'd0);
    read_exp("s1:cause", 5'd13, 32'h0000_1000);
    read_exp("s1:epc", 5'd14, 32'h0000_1000);
    cycle("s1_rd");

    // Exception in a delay slot with IE=0
    drive(1'b1, 5'd12, 32'd0, 5'd0, 1'b0, 32'd0, 6'd0, 1'b1);
    cycle("s2_clr");
    drive(1'b0, 5'd0, 32'd0, 5'd4, 1'b1, 32'h0000_3008, 6'd0, 1'b0);
    #1;
    check_eq("s2:req_now", {31'd0, Req}, 32'd1);
    cycle("s2_exc");
    read_exp("s2:epc", 5'd14, 32'h0000_3004);
    read_exp("s2:cause", 5'd13, 32'h8000_0010);
    cycle("s2_rd");

    // Interrupt and exception together: interrupt wins
    drive(1'b1, 5'd12, 32'h0000_FC01, 5'd0, 1'b0, 32'd0, 6'd0, 1'b1);
    cycle("s3_clr");
    drive(1'b0, 5'd0, 32'd0, 5'd10, 1'b0, 32'h0000_2000, 6'b000001, 1'b0);
    cycle("s3_both");
    read_exp("s3:cause", 5'd13, 32'h0000_0400);
    cycle("s3_rd");

    // EXL masks new exceptions; eret clears EXL
    drive(1'b0, 5'd0, 32'd0, 5'd12, 1'b0, 32'h0000_5000, 6'd0, 1'b0);
    #1;
    check_eq("s4:req_masked", {31'd0, Req}, 32'd0);
    cycle("s4_exc");
    read_exp("s4:epc", 5'd14, 32'h0000_2000);
    cycle("s4_rd");
    drive(1'b0, 5'd12, 32'd0, 5'd0, 1'b0, 32'd0, 6'd0, 1'b1);
    cycle("s4_eret");
    read_exp("s4:sr", 5'd12, 32'h0000_FC01);
    cycle("s4_rd2");

    // mtc0 EPC suppressed by Req on the same edge
    drive(1'b1, 5'd14, 32'h0000_3100, 5'd8, 1'b0, 32'h0000_2468, 6'd0, 1'b0);
    #1;
    check_eq("s5:epcout", EPCOut, 32'h0000_2000);
    cycle("s5_wr");
    read_exp("s5:epc", 5'd14, 32'h0000_2468);

    // Asynchronous reset mid-cycle with EXL=1 and EPC nonzero
    #2;
    reset = 1'b0;
    m_clear();
    read_exp("s6:sr", 5'd12, 32'd0);
    read_exp("s6:cause", 5'd13, 32'd0);
    read_exp("s6:epc", 5'd14, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd12, 32'd0, 5'd4, 1'b0, 32'h0000_7777, 6'd0, 1'b0);
    cycle("s6_hold");
    reset = 1'b1;
    drive(1'b0, 5'd14, 32'd0, 5'd0, 1'b0, 32'd0, 6'd0, 1'b0);
    cycle("s6_rel");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] addr;
      case ($urandom % 6)
        0: addr = 5'd12;
        1: addr = 5'd13;
        2: addr = 5'd14;
        3: addr = 5'd15;
        default: addr = 5'($urandom);
      endcase
      drive(1'($urandom % 2), addr, $urandom,
            ($urandom % 4 == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
            1'($urandom), $urandom,
            ($urandom % 3 == 0) ? 6'($urandom) : 6'd0,
            ($urandom % 4 == 0));
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
